// File: rtl/bepu_led_segment_pkg.sv
// Shared constants for the LED / seven-segment back-end peripheral.
// Latency: n/a (package). Backpressure: n/a.
// Holds the hex-to-segment table, blanking constants and control-register layout.
package bepu_led_segment_pkg;

  // Active-low gfedcba patterns, entry 0 at the right-hand end.
  localparam logic [15:0][6:0] HEX_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Control register layout within the write data word.
  localparam int CTRL_DP_LSB = 0;
  localparam int CTRL_DP_MSB = 7;
  localparam int CTRL_EN_LSB = 8;
  localparam int CTRL_EN_MSB = 15;

  typedef struct packed {
    logic [7:0] en_mask;   // 1 = digit slot lit
    logic [7:0] dp;        // 1 = decimal point on
  } ctrl_t;

endpackage

// File: rtl/bepu_led_segment_hex7seg.sv
// Purpose: combinational 4-bit hex to 7-segment active-low decoder.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Ports: i_nibble - hex digit value; o_seg - gfedcba cathodes, active-low.
module bepu_led_segment_hex7seg
  import bepu_led_segment_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  assign o_seg = HEX_LUT[i_nibble];

endmodule

// File: rtl/bepu_led_segment.sv
// Purpose: latches bus writes into LED / segment / control registers and scans 8 hex digits.
// Latency: led visible 1 cycle after the write edge; an/seg lag register/digit changes by 1 cycle.
// Backpressure: none; every write strobe is accepted in the cycle it is presented.
// Ports:
//   clk, rst          - rising-edge clock, asynchronous active-low reset
//   bus_select/_w/_data - chip-select vector, write strobe, write data from the front end
//   led               - 16 discrete LEDs, active-high
//   seg / an          - shared segment cathodes and digit anodes, both active-low
module bepu_led_segment
  import bepu_led_segment_pkg::*;
#(
  parameter int unsigned SEL_LED  = 0,
  parameter int unsigned SEL_SEG  = 1,
  parameter int unsigned SEL_CTRL = 2,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_select,
  input  logic        bus_w,
  input  logic [31:0] bus_data,
  output logic [15:0] led,
  output logic [7:0]  seg,
  output logic [7:0]  an
);

  // 20 bits covers the largest legal divider (2^20 - 1 terminal count).
  localparam logic [19:0] PRESC_LAST = 20'(SCAN_DIV - 1);

  logic [15:0] r_led;
  logic [31:0] r_seg_val;
  ctrl_t       r_ctrl;
  logic [19:0] r_presc;
  logic [2:0]  r_digit;
  logic [7:0]  r_an;
  logic [7:0]  r_seg;

  logic        w_wr_led;
  logic        w_wr_seg;
  logic        w_wr_ctrl;
  logic        w_presc_wrap;
  logic [3:0]  w_nibble;
  logic [6:0]  w_hex;
  logic [7:0]  w_an_nxt;
  logic [7:0]  w_seg_nxt;
  logic        w_unused_sel;

  // Only three select bits are decoded; the rest are deliberately ignored.
  assign w_unused_sel = &{1'b0, bus_select};

  assign w_wr_led  = bus_w & bus_select[SEL_LED];
  assign w_wr_seg  = bus_w & bus_select[SEL_SEG];
  assign w_wr_ctrl = bus_w & bus_select[SEL_CTRL];

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_led          <= 16'h0000;
      r_seg_val      <= 32'h0000_0000;
      r_ctrl.dp      <= 8'h00;
      r_ctrl.en_mask <= 8'hFF;
    end else begin
      if (w_wr_led) r_led <= bus_data[15:0];
      if (w_wr_seg) r_seg_val <= bus_data;
      if (w_wr_ctrl) begin
        r_ctrl.dp      <= bus_data[CTRL_DP_MSB:CTRL_DP_LSB];
        r_ctrl.en_mask <= bus_data[CTRL_EN_MSB:CTRL_EN_LSB];
      end
    end
  end

  // ------------------------------------------------------------- scan counter
  assign w_presc_wrap = (r_presc == PRESC_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= 20'd0;
      r_digit <= 3'd0;
    end else if (w_presc_wrap) begin
      r_presc <= 20'd0;
      r_digit <= r_digit + 3'd1;   // natural 3-bit wrap 7 -> 0
    end else begin
      r_presc <= r_presc + 20'd1;
    end
  end

  // ------------------------------------------------------------ digit decode
  assign w_nibble = r_seg_val[{r_digit, 2'b00} +: 4];

  bepu_led_segment_hex7seg u_hex7seg (
    .i_nibble (w_nibble),
    .o_seg    (w_hex)
  );

  // A disabled slot stays dark for its full time; the scan does not skip it.
  always_comb begin
    w_an_nxt  = AN_OFF;
    w_seg_nxt = SEG_BLANK;
    if (r_ctrl.en_mask[r_digit]) begin
      w_an_nxt  = ~(8'b0000_0001 << r_digit);
      w_seg_nxt = {~r_ctrl.dp[r_digit], w_hex};
    end
  end

  // Registered outputs keep the pad drivers glitch-free from decode logic.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_an  <= 8'hFE;
      r_seg <= 8'hC0;
    end else begin
      r_an  <= w_an_nxt;
      r_seg <= w_seg_nxt;
    end
  end

  assign led = r_led;
  assign seg = r_seg;
  assign an  = r_an;

endmodule

// File: tb/tb_bepu_led_segment.sv
module tb_bepu_led_segment;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] bus_select = 32'h0;
  logic        bus_w = 1'b0;
  logic [31:0] bus_data = 32'h0;
  logic [15:0] led;
  logic [7:0]  seg;
  logic [7:0]  an;

  always #5 clk = ~clk;

  bepu_led_segment #(
    .SEL_LED (0),
    .SEL_SEG (1),
    .SEL_CTRL(2),
    .SCAN_DIV(SD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_select(bus_select),
    .bus_w     (bus_w),
    .bus_data  (bus_data),
    .led       (led),
    .seg       (seg),
    .an        (an)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: architectural registers plus count of edges since reset release.
  logic [6:0]  hex_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [15:0] m_led;
  logic [31:0] m_val;
  logic [7:0]  m_dp;
  logic [7:0]  m_en;
  int          m_edges;
  logic [7:0]  e_an;
  logic [7:0]  e_seg;

  // {an, seg} that slot d shows given the current model registers.
  function automatic logic [15:0] ref_disp(int d);
    logic [3:0] nib;
    nib = m_val[4*d +: 4];
    if (!m_en[d]) return 16'hFFFF;
    return {~(8'(1) << d), ~m_dp[d], hex_ref[nib]};
  endfunction

  task automatic model_reset();
    m_led = 16'h0; m_val = 32'h0; m_dp = 8'h00; m_en = 8'hFF;
    m_edges = 0; e_an = 8'hFE; e_seg = 8'hC0;
  endtask

  // One clock: the edge displays the slot selected before it, then writes land.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      {e_an, e_seg} = ref_disp((m_edges / SD) % 8);
      if (bus_w) begin
        if (bus_select[0]) m_led = bus_data[15:0];
        if (bus_select[1]) m_val = bus_data;
        if (bus_select[2]) begin m_dp = bus_data[7:0]; m_en = bus_data[15:8]; end
      end
      m_edges++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; bus_w = 1'b1; bus_select = 32'hFFFF_FFFF; bus_data = $urandom;
    repeat (3) step();
    n_vec++;
    if ({led, an, seg} !== {16'h0, 8'hFE, 8'hC0}) begin
      n_bad++; $display("FAIL reset_hold: led/an/seg=%h/%h/%h want 0000/fe/c0", led, an, seg);
    end
    bus_w = 1'b0; bus_select = 32'h0; rst = 1'b1;
    model_reset();
    for (int i = 0; i < 40; i++) begin
      step();
      n_vec++;
      if ({led, an, seg} !== {m_led, e_an, e_seg}) begin
        n_bad++; $display("FAIL reset_scan[%0d]: led/an/seg=%h/%h/%h want %h/%h/%h", i, led, an, seg, m_led, e_an, e_seg);
      end
      if (i == 4 || i == 32) begin
        n_vec++;
        if (an !== (i == 4 ? 8'hFD : 8'hFE)) begin
          n_bad++; $display("FAIL reset_an_step[%0d]: an=%h want %h", i, an, (i == 4 ? 8'hFD : 8'hFE));
        end
      end
    end
  endtask

  task automatic test_led_write();
    bus_select = 32'h1; bus_w = 1'b1; bus_data = 32'hDEAD_BEEF;
    step();
    bus_w = 1'b0; bus_select = 32'h0; bus_data = $urandom;
    n_vec++;
    if (led !== 16'hBEEF) begin
      n_bad++; $display("FAIL led_write: led=%h want beef", led);
    end
    for (int i = 0; i < 32; i++) begin
      step();
      n_vec++;
      if ({led, an, seg} !== {m_led, e_an, e_seg} || seg !== 8'hC0) begin
        n_bad++; $display("FAIL led_scan[%0d]: led/an/seg=%h/%h/%h want %h/%h/c0", i, led, an, seg, m_led, e_an);
      end
    end
  endtask

  task automatic test_seg_write();
    logic [7:0] got [8];
    logic [7:0] want [8];
    want = '{8'h8E, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    for (int d = 0; d < 8; d++) got[d] = 8'hxx;
    bus_select = 32'h2; bus_w = 1'b1; bus_data = 32'h1234_ABCF;
    step();
    bus_w = 1'b0; bus_select = 32'h0;
    for (int i = 0; i < 33; i++) begin
      step();
      n_vec++;
      if ({led, an, seg} !== {m_led, e_an, e_seg}) begin
        n_bad++; $display("FAIL seg_scan[%0d]: led/an/seg=%h/%h/%h want %h/%h/%h", i, led, an, seg, m_led, e_an, e_seg);
      end
      for (int d = 0; d < 8; d++) if (an == ~(8'(1) << d)) got[d] = seg;
    end
    for (int d = 0; d < 8; d++) begin
      n_vec++;
      if (got[d] !== want[d]) begin
        n_bad++; $display("FAIL seg_digit[%0d]: seg=%h want %h", d, got[d], want[d]);
      end
    end
  endtask

  task automatic test_ctrl_write();
    int blank;
    logic [7:0] dp_seg;
    bus_select = 32'h4; bus_w = 1'b1; bus_data = 32'h0000_F001;
    step();
    bus_w = 1'b0; bus_select = 32'h0;
    step();
    blank = 0;
    for (int i = 0; i < 32; i++) begin
      step();
      n_vec++;
      if ({led, an, seg} !== {m_led, e_an, e_seg}) begin
        n_bad++; $display("FAIL ctrl_scan[%0d]: led/an/seg=%h/%h/%h want %h/%h/%h", i, led, an, seg, m_led, e_an, e_seg);
      end
      if (an == 8'hFF && seg == 8'hFF) blank++;
    end
    n_vec++;
    if (blank != 16) begin
      n_bad++; $display("FAIL ctrl_blank_slots: dark cycles=%0d want 16", blank);
    end
    // Unblank everything but keep dp on digit 0 (value F -> 0E with dp lit).
    bus_select = 32'h4; bus_w = 1'b1; bus_data = 32'h0000_FF01;
    step();
    bus_w = 1'b0; bus_select = 32'h0;
    dp_seg = 8'hxx;
    for (int i = 0; i < 33; i++) begin
      step();
      if (an == 8'hFE && i > 0) dp_seg = seg;
    end
    n_vec++;
    if (dp_seg !== 8'h0E) begin
      n_bad++; $display("FAIL ctrl_dp_digit0: seg=%h want 0e", dp_seg);
    end
  endtask

  task automatic test_multi_select();
    bus_select = 32'h3; bus_w = 1'b1; bus_data = 32'h0000_5555;
    step();
    bus_select = 32'h7; bus_w = 1'b0; bus_data = $urandom;
    n_vec++;
    if (led !== 16'h5555) begin
      n_bad++; $display("FAIL multi_led: led=%h want 5555", led);
    end
    for (int i = 0; i < 33; i++) begin
      step();
      bus_data = $urandom;
      n_vec++;
      if ({led, an, seg} !== {m_led, e_an, e_seg} || led !== 16'h5555) begin
        n_bad++; $display("FAIL multi_nowrite[%0d]: led/an/seg=%h/%h/%h want %h/%h/%h", i, led, an, seg, m_led, e_an, e_seg);
      end
    end
    bus_select = 32'h0;
  endtask

  task automatic test_async_reset();
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      if (e_an == 8'hDF) hit = 1'b1;
    end
    n_vec++;
    if (!hit || an !== 8'hDF) begin
      n_bad++; $display("FAIL async_reach_digit5: an=%h want df", an);
    end
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({led, an, seg} !== {16'h0, 8'hFE, 8'hC0}) begin
      n_bad++; $display("FAIL async_reset: led/an/seg=%h/%h/%h want 0000/fe/c0", led, an, seg);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 12; i++) begin
      step();
      n_vec++;
      if ({led, an, seg} !== {m_led, e_an, e_seg}) begin
        n_bad++; $display("FAIL async_restart[%0d]: led/an/seg=%h/%h/%h want %h/%h/%h", i, led, an, seg, m_led, e_an, e_seg);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus_w      = ($urandom_range(0, 3) == 0);
      bus_select = $urandom;
      bus_data   = $urandom;
      step();
      n_vec++;
      if ({led, an, seg} !== {m_led, e_an, e_seg}) begin
        n_bad++; $display("FAIL random[%0d]: led/an/seg=%h/%h/%h want %h/%h/%h", i, led, an, seg, m_led, e_an, e_seg);
      end
    end
    bus_w = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_led_write();
    test_seg_write();
    test_ctrl_write();
    test_multi_select();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
